// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- memory-access stage plus MEM/WB pipeline register of the
// 8-bit five-stage CPU.
//
// Takes the EX/MEM latch outputs, performs stores/loads against an on-chip
// data memory, and registers the write-back controls and data for WB.
//
// Parameters:
//   DEPTH   number of 8-bit data words (2..256)
//   ADDR_W  address width taken from ALUout (2**ADDR_W >= DEPTH)
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   WBregwr, WBregomem         EX/MEM write-back controls
//   MEMwr, MEMrd               EX/MEM store / load enables
//   ALUout                     ALU result, also the memory address
//   readDATA2, constant        store data, immediate pass-through
//   writeREG                   destination register
//   stall, flush               hold MEM/WB / insert bubble (both block stores)
//   MWregwr, MWwriteREG,
//   MWwbDATA, MWconstant       registered MEM/WB outputs
//   addr_err                   sticky out-of-range access flag
//   load_cnt, store_cnt        committed access counters
//
// Optional feature: define MEMSTAT_EN to build the saturating load/store
// counters; otherwise both counter outputs are tied to zero.
module mem_wb_stage #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        WBregwr,
   input  logic        WBregomem,
   input  logic        MEMwr,
   input  logic [7:0]  ALUout,
   input  logic [7:0]  readDATA2,
   input  logic [7:0]  constant,
   input  logic [2:0]  writeREG,
   input  logic        MEMrd,
   input  logic        stall,
   input  logic        flush,
   output logic        MWregwr,
   output logic [2:0]  MWwriteREG,
   output logic [7:0]  MWwbDATA,
   output logic [7:0]  MWconstant,
   output logic        addr_err,
   output logic [15:0] load_cnt,
   output logic [15:0] store_cnt
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]       mem [DEPTH];
   logic             in_range;
   logic             live;
   logic             store_en;
   logic [IDX_W-1:0] idx;
   logic [7:0]       ld_data;
   logic [7:0]       wb_data;

   // Range check on the full 8 bits; the ADDR_W term also rejects addresses
   // wider than the configured address bus.
   assign in_range = (9'(ALUout) < 9'(DEPTH)) && ((9'(ALUout) >> ADDR_W) == 9'd0);
   // Index truncation is safe: every use of idx is qualified by in_range.
   assign idx      = ALUout[IDX_W-1:0];
   assign live     = !stall && !flush;
   assign store_en = MEMwr && live && in_range;

   // Combinational read sees the pre-write contents on a store edge, so an
   // illegal store+load returns the old data.
   assign ld_data = in_range ? mem[idx] : 8'h00;
   assign wb_data = WBregomem ? ld_data : ALUout;

   // Data memory is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (store_en) mem[idx] <= readDATA2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MWregwr    <= 1'b0;
         MWwriteREG <= 3'd0;
         MWwbDATA   <= 8'h00;
         MWconstant <= 8'h00;
      end else if (flush) begin
         MWregwr    <= 1'b0;
         MWwriteREG <= 3'd0;
         MWwbDATA   <= 8'h00;
         MWconstant <= 8'h00;
      end else if (!stall) begin
         MWregwr    <= WBregwr;
         MWwriteREG <= writeREG;
         MWwbDATA   <= wb_data;
         MWconstant <= constant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    addr_err <= 1'b0;
      else if ((MEMwr || MEMrd) && live && !in_range) addr_err <= 1'b1;
   end

`ifdef MEMSTAT_EN
   logic load_en;
   assign load_en = MEMrd && live && in_range;

   // Saturating counters: hold at all-ones rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt  <= 16'h0000;
         store_cnt <= 16'h0000;
      end else begin
         if (load_en  && load_cnt  != 16'hFFFF) load_cnt  <= load_cnt  + 16'd1;
         if (store_en && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
      end
   end
`else
   assign load_cnt  = 16'h0000;
   assign store_cnt = 16'h0000;
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage and MEM/WB pipeline register of the 8-bit five-stage CPU. It consumes the EX/MEM latch outputs and performs stores into an on-chip data memory and loads from it. It then registers the results and write-back controls for the WB stage. It includes stall and flush control, out-of-range address detection and optional access statistics.

## Interface
Parameters:
- DEPTH, 256, number of 8-bit data-memory words; legal range 2..256.
- ADDR_W, 8, address width taken from ALUout; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- WBregwr  input  1  EX/MEM register-write enable.
- WBregomem  input  1  EX/MEM write-back select; 1 = memory data, 0 = ALU result.
- MEMwr  input  1  EX/MEM store enable.
- ALUout  input  8  EX/MEM ALU result; also the memory address.
- readDATA2  input  8  EX/MEM store data.
- constant  input  8  EX/MEM immediate, passed through.
- writeREG  input  3  EX/MEM destination register.
- MEMrd  input  1  EX/MEM load enable.
- stall  input  1  hold MEM/WB contents and suppress the store.
- flush  input  1  insert a bubble into MEM/WB and suppress the store.
- MWregwr  output  1  registered register-write enable.
- MWwriteREG  output  3  registered destination register.
- MWwbDATA  output  8  registered write-back data.
- MWconstant  output  8  registered immediate.
- addr_err  output  1  sticky flag for an out-of-range access.
- load_cnt  output  16  number of loads (MEMSTAT_EN only).
- store_cnt  output  16  number of stores (MEMSTAT_EN only).

## Operation
- Access is in range when ALUout < DEPTH, compared on the full 8 bits.
- Store: on a rising edge with MEMwr=1, stall=0, flush=0 and the address in range, mem[ALUout] <= readDATA2. Otherwise memory is unchanged.
- Load data is mem[ALUout] if the address is in range, else 8'h00. The read is combinational from the array.
- The same-edge read returns the pre-write contents.
- Write-back data is load data when WBregomem=1, else ALUout.
- MEM/WB update on each rising edge, with priority flush > stall > normal:
  - flush=1: MWregwr <= 0; MWwriteREG, MWwbDATA and MWconstant <= 0.
  - stall=1, flush=0: all MW* registers hold.
  - normal: MWregwr <= WBregwr, MWwriteREG <= writeREG, MWwbDATA <= write-back data, MWconstant <= constant.
- addr_err is set on a rising edge when MEMwr or MEMrd is 1, stall=0, flush=0 and the address is out of range. It stays set until reset.
- MEMwr and MEMrd both 1 is illegal. It is handled as a store plus a load, and the load sees the old data.
- Data memory contents are not affected by reset. Simulation initial contents are X.

## Timing
- Reset (rst_n=0, asynchronous): MWregwr=0, MWwriteREG=0, MWwbDATA=0, MWconstant=0, addr_err=0, load_cnt=0, store_cnt=0. Memory is untouched.
- Latency: inputs present in cycle N appear on the MW* outputs after the edge that ends cycle N (one cycle).
- A store commits on the same edge. A load issued in the following cycle returns the new data.
- Stall: the store is retried in the first non-stalled cycle, because the EX/MEM latch holds its inputs.
- Reset deasserted mid-stall: the outputs stay at 0 while stall remains high.

## Configuration
- MEMSTAT_EN defined:
  - load_cnt increments on each committed load (MEMrd=1, stall=0, flush=0, address in range).
  - store_cnt increments on each committed store.
  - Both counters saturate at 16'hFFFF.
- MEMSTAT_EN undefined: no counter flops; load_cnt and store_cnt are tied to 16'h0000.

## Test plan
- Store then load: store 8'hA5 to address 8'h10 (MEMwr=1), then a load from 8'h10 with WBregomem=1, WBregwr=1, writeREG=3 -> one cycle later MWwbDATA=8'hA5, MWregwr=1, MWwriteREG=3.
- ALU pass-through: WBregomem=0, ALUout=8'h3C, constant=8'h07 -> next cycle MWwbDATA=8'h3C, MWconstant=8'h07; memory unchanged.
- Stall and flush:
  - stall=1 with MEMwr=1 to address 8'h20, data 8'h55 -> mem[8'h20] unchanged and MW* hold.
  - Release stall -> mem[8'h20]=8'h55.
  - flush=1 together with stall=1 -> MWregwr=0 and no store.
- Out of range: DEPTH=16, load from 8'h20 -> MWwbDATA=8'h00, addr_err=1, and it stays set across later legal accesses.
- Async reset mid-operation: pulse rst_n low between clock edges -> all outputs 0 immediately; previously stored 8'hA5 at 8'h10 still loads back afterwards.
- MEMSTAT_EN: 3 stores and 2 loads (1 of them flushed) -> store_cnt=3, load_cnt=1. A preloaded count of 16'hFFFF does not wrap.
